// File: rtl/kv_pkg.sv
// rtl/kv_pkg.sv - constants and state types shared by the kv command and response paths
package kv_pkg;

    localparam int KV_TICKS_PER_BIT = 16;
    localparam int KV_KEY_W         = 32;
    localparam int KV_VAL_W         = 32;

    localparam logic [7:0] OP_ISSUE    = 8'h01;
    localparam logic [7:0] OP_TRANSFER = 8'h02;
    localparam logic [7:0] OP_REFER    = 8'h03;
    localparam logic [7:0] OP_CREATE   = 8'h04;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_NOKEY  = 8'h01;
    localparam logic [7:0] ST_INSUFF = 8'h02;
    localparam logic [7:0] ST_FULL   = 8'h03;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_e;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_SEND = 1'b1
    } frame_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 single-byte serializer paced by an oversample tick
module uart_tx_byte
    import kv_pkg::*;
#(
    parameter int TICKS_PER_BIT = KV_TICKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_done,
    output logic       tx
);

    localparam int CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_BIT - 1);

    ser_state_e     state_q, state_d;
    logic [CW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           bit_end;

    // Next-state: a new byte may be loaded from IDLE or straight out of the stop bit (no gap)
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = 1'b1;
        bit_end    = tick_in && (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
        byte_done  = bit_end && (state_q == S_STOP);

        if (tick_in && (state_q != S_IDLE)) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (byte_valid) begin
                    state_d    = S_START;
                    shift_d    = byte_data;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_valid) begin
                        state_d   = S_START;
                        shift_d   = byte_data;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the current state, registered so tx trails the state by one clk
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State registers; reset drives the line idle-high immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/kv_response_tx.sv
// rtl/kv_response_tx.sv - frames a kv result and sends it as UART bytes; KV_RSP_CHECKSUM_EN appends an XOR byte
module kv_response_tx
    import kv_pkg::*;
#(
    parameter int TICKS_PER_BIT = KV_TICKS_PER_BIT,
    parameter int KEY_W         = KV_KEY_W,
    parameter int VAL_W         = KV_VAL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [7:0]       rsp_opcode,
    input  logic [7:0]       rsp_status,
    input  logic [KEY_W-1:0] rsp_key,
    input  logic [VAL_W-1:0] rsp_value,
    output logic             tx,
    output logic             busy
);

    // KEY_W and VAL_W are byte multiples, so the body is a whole number of bytes
    localparam int BODY_BYTES = 2 + KEY_W / 8 + VAL_W / 8;
`ifdef KV_RSP_CHECKSUM_EN
    localparam int FRAME_BYTES = BODY_BYTES + 1;
`else
    localparam int FRAME_BYTES = BODY_BYTES;
`endif
    localparam int FW = FRAME_BYTES * 8;
    localparam int IW = $clog2(FRAME_BYTES);
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BYTES - 1);

    frame_state_e          state_q, state_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BODY_BYTES*8-1:0] body;
    logic                  accept;
    logic                  last_byte;
    logic                  byte_valid;
    logic                  byte_done;
    logic [7:0]            byte_data;

    // Frame body in wire order: opcode, status, key MSB-first, value MSB-first
    assign body = {rsp_opcode, rsp_status, rsp_key, rsp_value};

`ifdef KV_RSP_CHECKSUM_EN
    logic [7:0] checksum;

    // XOR of every body byte, folded in at capture time
    always_comb begin
        checksum = '0;
        for (int i = 0; i < BODY_BYTES; i++) begin
            checksum = checksum ^ body[i*8 +: 8];
        end
    end
`endif

    assign rsp_ready = (state_q == F_IDLE);
    assign busy      = (state_q == F_SEND);

    // Frame sequencing: the top byte of frame_q is always the byte on the wire
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        accept    = rsp_valid && (state_q == F_IDLE);
        last_byte = (idx_q == IDX_LAST);
        // The opcode is handed over on the accept edge so the start bit is timed from accept
        byte_valid = accept || ((state_q == F_SEND) && !(byte_done && last_byte));
        if (accept) begin
            byte_data = rsp_opcode;
        end else if (byte_done) begin
            byte_data = frame_q[FW-9 -: 8];
        end else begin
            byte_data = frame_q[FW-1 -: 8];
        end

        case (state_q)
            F_IDLE: begin
                if (accept) begin
                    state_d = F_SEND;
                    idx_d   = '0;
`ifdef KV_RSP_CHECKSUM_EN
                    frame_d = {body, checksum};
`else
                    frame_d = body;
`endif
                end
            end
            F_SEND: begin
                if (byte_done) begin
                    if (last_byte) begin
                        state_d = F_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        frame_d = {frame_q[FW-9:0], 8'h00};
                    end
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    // Frame registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= F_IDLE;
            frame_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
        end
    end

    uart_tx_byte #(
        .TICKS_PER_BIT(TICKS_PER_BIT)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .tx        (tx)
    );

endmodule
